// File: rtl/tl_ul_port_buffer.sv
// TileLink-UL port buffer: registered A and D channel FIFOs plus an
// outstanding-request counter that throttles new A requests.

module tl_ul_port_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_enq,
  input  logic [W-1:0] i_wdata,
  input  logic         i_deq,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_enq_ptr;
  logic [PW-1:0]   r_deq_ptr;
  logic [CNTW-1:0] r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_count   <= '0;
    end else begin
      if (i_enq) r_enq_ptr <= next_ptr(r_enq_ptr);
      if (i_deq) r_deq_ptr <= next_ptr(r_deq_ptr);
      if (i_enq && !i_deq)      r_count <= r_count + 1'b1;
      else if (i_deq && !i_enq) r_count <= r_count - 1'b1;
    end
  end

  // Payload storage carries no reset; validity lives entirely in r_count.
  always_ff @(posedge clock) begin
    if (i_enq) r_mem[r_enq_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_deq_ptr];
  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

module tl_ul_port_buffer #(
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2,
  parameter int MAX_INFLIGHT = 2,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_a_valid,
  output logic          in_a_ready,
  input  logic [74:0]   in_a_bits,
  output logic          out_a_valid,
  input  logic          out_a_ready,
  output logic [74:0]   out_a_bits,
  input  logic          in_d_valid,
  output logic          in_d_ready,
  input  logic [41:0]   in_d_bits,
  output logic          out_d_valid,
  input  logic          out_d_ready,
  output logic [41:0]   out_d_bits,
  output logic [CW-1:0] inflight,
  output logic          underflow_err
);
  // Handshake: a transfer happens on a channel exactly when valid && ready
  // are both high at a rising clock edge; readies come from registers only.
  logic          r_live;
  logic [CW-1:0] r_inflight;
  logic          r_underflow;
  logic          w_a_full, w_a_empty, w_d_full, w_d_empty;
  logic          w_a_in_fire, w_a_out_fire, w_d_in_fire, w_d_out_fire;

  assign in_a_ready   = r_live && !w_a_full && (r_inflight < CW'(MAX_INFLIGHT));
  assign in_d_ready   = r_live && !w_d_full;
  assign out_a_valid  = !w_a_empty;
  assign out_d_valid  = !w_d_empty;
  assign w_a_in_fire  = in_a_valid && in_a_ready;
  assign w_a_out_fire = out_a_valid && out_a_ready;
  assign w_d_in_fire  = in_d_valid && in_d_ready;
  assign w_d_out_fire = out_d_valid && out_d_ready;

  tl_ul_port_fifo #(.DEPTH(A_DEPTH), .W(75)) u_a_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_enq   (w_a_in_fire),
    .i_wdata (in_a_bits),
    .i_deq   (w_a_out_fire),
    .o_rdata (out_a_bits),
    .o_full  (w_a_full),
    .o_empty (w_a_empty)
  );

  tl_ul_port_fifo #(.DEPTH(D_DEPTH), .W(42)) u_d_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_enq   (w_d_in_fire),
    .i_wdata (in_d_bits),
    .i_deq   (w_d_out_fire),
    .o_rdata (out_d_bits),
    .o_full  (w_d_full),
    .o_empty (w_d_empty)
  );

  // r_live keeps both readies low until the first edge after reset falls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_live      <= 1'b0;
      r_inflight  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_a_in_fire && !w_d_out_fire) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (w_d_out_fire && !w_a_in_fire) begin
        if (r_inflight == '0) r_underflow <= 1'b1;
        else                  r_inflight  <= r_inflight - 1'b1;
      end
    end
  end

  assign inflight      = r_inflight;
  assign underflow_err = r_underflow;
endmodule

// File: doc/tl_ul_port_buffer.md
# tl_ul_port_buffer

TileLink-UL port buffer that sits directly upstream of the TileLink protocol monitor and slave port. It registers the A (request) channel and D (response) channel through independent circular FIFOs. It also bounds the number of outstanding requests with an in-flight counter. The monitor observes the buffered `out_a_*` and `in_d_*` handshakes this block produces and consumes.

## Interface
Parameters:
- `A_DEPTH`, 2, A-channel FIFO entries (power of two, ≥1)
- `D_DEPTH`, 2, D-channel FIFO entries (power of two, ≥1)
- `MAX_INFLIGHT`, 2, maximum requests accepted on `in_a` and not yet returned on `out_d` (≥1)
- `CW`, derived, clog2(`MAX_INFLIGHT`+1), width of `inflight`

Ports:
- **Clock/reset.** One clock; reset is asynchronous and active-high.
  - `clock` in 1 — sole clock, rising edge
  - `reset` in 1 — asynchronous reset
- **A channel, master side.**
  - `in_a_valid` in 1 — request valid from master
  - `in_a_ready` out 1 — buffer accepts request
  - `in_a_bits` in 75 — {opcode[2:0], param[2:0], size[1:0], source[0], address[29:0], mask[3:0], data[31:0]}, MSB first
- **A channel, slave side.**
  - `out_a_valid` out 1 — buffered request valid
  - `out_a_ready` in 1 — slave accepts request
  - `out_a_bits` out 75 — head-of-FIFO request, same packing as `in_a_bits`
- **D channel, slave side.**
  - `in_d_valid` in 1 — response valid from slave
  - `in_d_ready` out 1 — buffer accepts response
  - `in_d_bits` in 42 — {opcode[2:0], param[1:0], size[1:0], source[0], denied, data[31:0], corrupt}
- **D channel, master side.**
  - `out_d_valid` out 1 — buffered response valid
  - `out_d_ready` in 1 — master accepts response
  - `out_d_bits` out 42 — head-of-FIFO response
- **Status.**
  - `inflight` out CW — current outstanding request count
  - `underflow_err` out 1 — sticky; set when a response is delivered with `inflight`==0

## Operation
- **Fire definition.** A "fire" on any channel is `valid && ready` in the same cycle.
- **FIFO structure.** Each FIFO has a storage array, `enq_ptr`, `deq_ptr` and `count` (0..DEPTH).
  - Pointers wrap modulo DEPTH.
  - Storage is not reset.
- **Enqueue and dequeue.**
  - Enqueue on input fire: write bits at `enq_ptr`, advance `enq_ptr`.
  - Dequeue on output fire: advance `deq_ptr`.
  - `count` +1 on enqueue only, −1 on dequeue only, unchanged on both.
- **Output valids.** `out_x_valid` = (`count` != 0). `out_x_bits` = storage[`deq_ptr`], undefined while `out_x_valid`=0.
- **No flow-through, no pipe bypass.**
  - An empty FIFO never presents input bits in the same cycle.
  - A full FIFO deasserts `in_x_ready` even if the output fires that cycle.
- **Ready equations.**
  - `in_d_ready` = (D `count` < `D_DEPTH`).
  - `in_a_ready` = (A `count` < `A_DEPTH`) && (`inflight` < `MAX_INFLIGHT`).
  - Both are derived from registered state only; neither depends combinationally on any input.
- **In-flight counter.**
  - +1 on `in_a` fire and −1 on `out_d` fire.
  - Unchanged when both fire in the same cycle, or when neither fires.
- **Underflow.**
  - Condition: `out_d` fires with `inflight`==0 and `in_a` does not fire in the same cycle.
  - Response: `inflight` holds at 0 and `underflow_err` sets.
  - `underflow_err` clears only on reset.
- **Field handling.** Bits are carried verbatim; the block does no field decoding and no reordering (strict FIFO per channel).

## Timing
- **While `reset`=1 (asynchronous):**
  - pointers, counts, `inflight` and `underflow_err` = 0;
  - `out_a_valid` = `out_d_valid` = 0;
  - `in_a_ready` = `in_d_ready` = 0.
- **First rising edge after `reset` falls:** both readies = 1; valids remain 0.
- **Latency:** input fire at edge N gives `out_x_valid` high from after edge N, i.e. visible in cycle N+1. Minimum latency is 1 cycle.
- **Throughput:** 1 transfer/cycle per channel when DEPTH≥2 and both sides are ready. DEPTH=1 gives 1 transfer per 2 cycles.
- **`inflight` timing:** `inflight` updates at the edge of the fire. `in_a_ready` reflects the limit in the following cycle.
- **Reset mid-operation:** all buffered entries are discarded immediately and `inflight` clears. No output handshake completes in a cycle where `reset`=1.

## Test plan
- **Reset.** Assert `reset` for 3 cycles with random inputs -> all valids/readies 0, `inflight`=0, `underflow_err`=0. Readies go 1 in the first cycle after deassert.
- **Single transaction.**
  - Stimulus: `in_a` fires in cycle 1 with address 0x0000_1234, data 0xDEADBEEF, source 1.
  - A path: `out_a_valid`=1 in cycle 2 with identical bits; `inflight`=1.
  - D path: `in_d` fires in cycle 4 with data 0xCAFEF00D -> `out_d_valid` in cycle 5; `out_d` fire -> `inflight`=0.
- **A backpressure.**
  - Stimulus: `out_a_ready`=0, `MAX_INFLIGHT`=4, 3 back-to-back requests.
  - Response: first two accepted, `in_a_ready`=0 from cycle 3, third held.
  - Release: `out_a_ready`=1 -> outputs drain in order (#1, #2). Third request is accepted in the cycle after the first `out_a` fire.
- **In-flight limit.**
  - Stimulus: `MAX_INFLIGHT`=2, `out_a_ready`=1, no responses.
  - Response: after 2 accepts `in_a_ready`=0 with the A FIFO empty.
  - Recovery: one `out_d` fire -> `inflight`=1, `in_a_ready`=1 next cycle.
- **Simultaneous events.** With `inflight`=1, `in_a` fire and `out_d` fire in the same cycle -> `inflight` stays 1. With the D FIFO full and `out_d` firing, `in_d_ready`=0 that cycle; `in_d_ready`=1 the next.
- **Underflow and wrap.**
  - Underflow: spurious D response delivered with `inflight`=0 -> `underflow_err`=1 sticky, `inflight`=0. Only reset clears it.
  - Wrap: 10 requests through `A_DEPTH`=2 emerge in order with intact bits across pointer wrap.
